// File: rtl/window_stream_selector.sv
// window_stream_selector: streams raster pixels through K-1 line buffers and emits every KxK window at STRIDE.
// Optional WIN_MAX_EN adds a registered unsigned max of the window on win_max.
module window_stream_selector #(
  parameter int K      = 3,
  parameter int W      = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [K*K*W-1:0] win_data,
  output logic [15:0]      win_row,
  output logic [15:0]      win_col,
  output logic             busy,
  output logic             done
`ifdef WIN_MAX_EN
  ,
  output logic [W-1:0]     win_max
`endif
);
  localparam int L = (K-1)*IMG_W + K - 1;
  localparam logic [15:0] KM1    = 16'(K-1);
  localparam logic [15:0] LAST_C = 16'(IMG_W-1);
  localparam logic [15:0] LAST_R = 16'(IMG_H-1);
  localparam logic [15:0] SM1    = 16'(STRIDE-1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_FIN} state_t;

  state_t           r_state, w_next;
  logic [W-1:0]     r_sr [L];
  logic [15:0]      r_row, r_col, r_rph, r_cph;
  logic [K*K*W-1:0] w_win, r_win;
  logic [15:0]      r_wrow, r_wcol;
  logic             r_valid;
  logic             w_acc, w_emit, w_last, w_col_end;

  assign in_ready  = (r_state == S_LOAD) && (!r_valid || win_ready);
  assign w_acc     = in_valid && in_ready;
  assign w_col_end = r_col == LAST_C;
  assign w_last    = w_col_end && r_row == LAST_R;
  assign w_emit    = w_acc && r_row >= KM1 && r_col >= KM1 && r_rph == '0 && r_cph == '0;
  assign win_valid = r_valid;
  assign win_data  = r_win;
  assign win_row   = r_wrow;
  assign win_col   = r_wcol;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    busy   = r_state != S_IDLE;
    done   = r_state == S_FIN;
    w_next = r_state == S_IDLE  ? (start ? S_LOAD : S_IDLE) :
             r_state == S_LOAD  ? (w_acc && w_last ? S_DRAIN : S_LOAD) :
             r_state == S_DRAIN ? (r_valid ? S_DRAIN : S_FIN) : S_IDLE;
  end

  // Phase counters replace (pos-K+1)%STRIDE: zero exactly on emitting rows/columns.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_rph <= '0;
      r_cph <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_row <= '0;
      r_col <= '0;
      r_rph <= '0;
      r_cph <= '0;
    end else if (w_acc) begin
      r_col <= w_col_end ? '0 : r_col + 16'd1;
      r_cph <= (w_col_end || r_col < KM1 || r_cph == SM1) ? '0 : r_cph + 16'd1;
      if (w_col_end) begin
        r_row <= r_row + 16'd1;
        r_rph <= (r_row < KM1 || r_rph == SM1) ? '0 : r_rph + 16'd1;
      end
    end

  always_ff @(posedge clk)
    if (w_acc) begin
      r_sr[0] <= in_data;
      for (int i = 1; i < L; i++) r_sr[i] <= r_sr[i-1];
    end

  // Window tap (x,y) lies D pixels behind the completing pixel; D==0 is in_data itself.
  genvar x, y;
  for (x = 0; x < K; x++) begin : g_x
    for (y = 0; y < K; y++) begin : g_y
      localparam int D = (K-1-x)*IMG_W + (K-1-y);
      if (D == 0) begin : g_new
        assign w_win[(x*K+y)*W +: W] = in_data;
      end else begin : g_old
        assign w_win[(x*K+y)*W +: W] = r_sr[D-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_win   <= '0;
      r_wrow  <= '0;
      r_wcol  <= '0;
    end else if (w_emit) begin
      r_valid <= 1'b1;
      r_win   <= w_win;
      r_wrow  <= r_row - KM1;
      r_wcol  <= r_col - KM1;
    end else if (r_valid && win_ready) begin
      r_valid <= 1'b0;
      r_win   <= '0;
      r_wrow  <= '0;
      r_wcol  <= '0;
    end

`ifdef WIN_MAX_EN
  logic [W-1:0] w_max, r_max;

  always_comb begin
    w_max = '0;
    for (int i = 0; i < K*K; i++)
      w_max = w_win[i*W +: W] > w_max ? w_win[i*W +: W] : w_max;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                  r_max <= '0;
    else if (w_emit)             r_max <= w_max;
    else if (r_valid && win_ready) r_max <= '0;

  assign win_max = r_max;
`endif
endmodule

// File: tb/tb_window_stream_selector.sv
// tb_window_stream_selector: drives two K=3 configurations (4x4 stride 1, 5x5 stride 2) against a window-list model.
// With WIN_MAX_EN a third K=2 3x3 instance checks win_max.
module tb_window_stream_selector;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, win_ready, sel;
  logic [7:0]  in_data;
  int          checks = 0, errors = 0;

  logic        a_in_ready, a_win_valid, a_busy, a_done;
  logic        b_in_ready, b_win_valid, b_busy, b_done;
  logic [71:0] a_win_data, b_win_data;
  logic [15:0] a_row, a_col, b_row, b_col;
  logic        in_ready_m, win_valid_m, busy_m, done_m;
  logic [71:0] win_data_m;
  logic [15:0] row_m, col_m;
`ifdef WIN_MAX_EN
  logic [7:0]  a_max, b_max, max_m;
  assign max_m = sel ? b_max : a_max;
`endif

  always #5 clk = ~clk;

  assign in_ready_m  = sel ? b_in_ready  : a_in_ready;
  assign win_valid_m = sel ? b_win_valid : a_win_valid;
  assign busy_m      = sel ? b_busy      : a_busy;
  assign done_m      = sel ? b_done      : a_done;
  assign win_data_m  = sel ? b_win_data  : a_win_data;
  assign row_m       = sel ? b_row       : a_row;
  assign col_m       = sel ? b_col       : a_col;

  window_stream_selector #(.K(3), .W(8), .IMG_W(4), .IMG_H(4), .STRIDE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start && !sel), .in_valid(in_valid && !sel),
    .in_ready(a_in_ready), .in_data(in_data), .win_valid(a_win_valid), .win_ready(win_ready),
    .win_data(a_win_data), .win_row(a_row), .win_col(a_col), .busy(a_busy), .done(a_done)
`ifdef WIN_MAX_EN
    , .win_max(a_max)
`endif
  );

  window_stream_selector #(.K(3), .W(8), .IMG_W(5), .IMG_H(5), .STRIDE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start && sel), .in_valid(in_valid && sel),
    .in_ready(b_in_ready), .in_data(in_data), .win_valid(b_win_valid), .win_ready(win_ready),
    .win_data(b_win_data), .win_row(b_row), .win_col(b_col), .busy(b_busy), .done(b_done)
`ifdef WIN_MAX_EN
    , .win_max(b_max)
`endif
  );

`ifdef WIN_MAX_EN
  logic        c_start, c_valid, c_in_ready, c_win_valid, c_busy, c_done;
  logic [7:0]  c_data, c_max;
  logic [31:0] c_win_data;
  logic [15:0] c_row, c_col;

  window_stream_selector #(.K(2), .W(8), .IMG_W(3), .IMG_H(3), .STRIDE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_valid), .in_ready(c_in_ready),
    .in_data(c_data), .win_valid(c_win_valid), .win_ready(1'b1), .win_data(c_win_data),
    .win_row(c_row), .win_col(c_col), .busy(c_busy), .done(c_done), .win_max(c_max)
  );
`endif

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_data = '0; sel = 1'b0;
`ifdef WIN_MAX_EN
    c_start = 1'b0; c_valid = 1'b0; c_data = '0;
`endif
    #3;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({in_ready_m, win_valid_m, busy_m, done_m, win_data_m, row_m, col_m} !== '0) begin
        errors++;
        $display("FAIL reset_state sel=%0d got rdy=%b val=%b busy=%b done=%b data=%h row=%0d col=%0d want all 0",
                 s, in_ready_m, win_valid_m, busy_m, done_m, win_data_m, row_m, col_m);
      end
    end
    sel = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  // Runs a whole frame; the model lists every window top-left in raster order from the rules directly.
  task automatic run_frame(input bit s, input bit rnd, input bit stall, input bit mid_start, output int done_cyc);
    int          iw = s ? 5 : 4, ih = s ? 5 : 4, st = s ? 2 : 1;
    int          n = iw * ih, idx = 0, dones = 0, stall_left = 0, got = 0;
    bit          stalled = 1'b0;
    logic [7:0]  pix [25];
    logic [71:0] eq [$];
    logic [7:0]  em [$];
    int          er [$], ec [$];
    logic [71:0] held;
    sel = s;
    for (int i = 0; i < n; i++) pix[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
    for (int r = 0; r + 3 <= ih; r += st)
      for (int c = 0; c + 3 <= iw; c += st) begin
        logic [71:0] d;
        logic [7:0]  m;
        m = '0;
        for (int x = 0; x < 3; x++)
          for (int y = 0; y < 3; y++) begin
            d[(x*3+y)*8 +: 8] = pix[(r+x)*iw + c + y];
            if (pix[(r+x)*iw + c + y] > m) m = pix[(r+x)*iw + c + y];
          end
        eq.push_back(d); er.push_back(r); ec.push_back(c); em.push_back(m);
      end
    done_cyc = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start    = (cyc == 0) || (mid_start && idx == 5);
      in_valid = (idx >= n) ? 1'b1 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data  = (idx < n) ? pix[idx] : 8'($urandom_range(0, 255));
      if (stall && !stalled && win_valid_m) begin
        stalled = 1'b1; stall_left = 5; held = win_data_m;
      end
      win_ready = (stall_left > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      #1;
      if (stall_left > 0) begin
        checks++;
        if (in_ready_m !== 1'b0 || win_valid_m !== 1'b1 || win_data_m !== held) begin
          errors++;
          $display("FAIL stall_hold got rdy=%b val=%b data=%h want rdy=0 val=1 data=%h",
                   in_ready_m, win_valid_m, win_data_m, held);
        end
        stall_left--;
      end
      if (idx >= n) begin
        checks++;
        if (in_ready_m !== 1'b0) begin
          errors++;
          $display("FAIL extra_input got in_ready=%b want 0", in_ready_m);
        end
      end
      if (in_valid && in_ready_m && idx < n) idx++;
      if (win_valid_m && win_ready) begin
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL extra_window got row=%0d col=%0d want none", row_m, col_m);
        end else begin
          if (win_data_m !== eq[0] || row_m !== 16'(er[0]) || col_m !== 16'(ec[0])) begin
            errors++;
            $display("FAIL window_%0d got data=%h row=%0d col=%0d want data=%h row=%0d col=%0d",
                     got, win_data_m, row_m, col_m, eq[0], er[0], ec[0]);
          end
`ifdef WIN_MAX_EN
          checks++;
          if (max_m !== em[0]) begin
            errors++;
            $display("FAIL win_max_%0d got %0d want %0d", got, max_m, em[0]);
          end
`endif
          void'(eq.pop_front()); void'(er.pop_front()); void'(ec.pop_front()); void'(em.pop_front());
          got++;
        end
      end
      if (done_m) begin
        dones++;
        done_cyc = cyc;
        checks++;
        if (eq.size() != 0) begin
          errors++;
          $display("FAIL early_done got %0d windows left want 0", eq.size());
        end
      end else if (dones > 0) begin
        checks++;
        if (busy_m !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_done got %b want 0", busy_m);
        end
        break;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    checks++;
    if (dones != 1 || eq.size() != 0) begin
      errors++;
      $display("FAIL frame_end sel=%0d got dones=%0d windows=%0d want dones=1 windows=%0d", s, dones, got, got + eq.size());
    end
  endtask

  task automatic test_basic();
    int t1, t5, tmp;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, t1);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, tmp);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, tmp);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, t5);
    checks++;
    if (t5 !== t1 || t1 < 0) begin
      errors++;
      $display("FAIL start_ignored_timing got done at %0d want %0d", t5, t1);
    end
  endtask

  task automatic test_reset_mid();
    int tmp;
    sel = 1'b0; win_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      @(negedge clk);
    end
    checks++;
    if (busy_m !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_frame got %b want 1", busy_m);
    end
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready_m, win_valid_m, busy_m, done_m, win_data_m, row_m, col_m} !== '0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b val=%b busy=%b done=%b row=%0d col=%0d want all 0",
               in_ready_m, win_valid_m, busy_m, done_m, row_m, col_m);
    end
    @(negedge clk) rst_n = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, tmp);
  endtask

  task automatic test_random();
    int tmp;
    for (int k = 0; k < 6; k++) run_frame(k[0], 1'b1, k >= 4, 1'b0, tmp);
  endtask

`ifdef WIN_MAX_EN
  task automatic test_win_max();
    logic [7:0] pix [9];
    logic [7:0] em [$];
    int idx = 0, k = 0;
    bit seen_done = 1'b0;
    pix = '{8'd9, 8'd1, 8'd4, 8'd2, 8'd8, 8'd3, 8'd7, 8'd5, 8'd6};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        logic [7:0] m;
        m = '0;
        for (int x = 0; x < 2; x++)
          for (int y = 0; y < 2; y++)
            if (pix[(r+x)*3 + c + y] > m) m = pix[(r+x)*3 + c + y];
        em.push_back(m);
      end
    @(negedge clk) c_start = 1'b1;
    @(negedge clk) c_start = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      c_valid = idx < 9;
      c_data  = idx < 9 ? pix[idx] : 8'd0;
      #1;
      if (c_valid && c_in_ready) idx++;
      if (c_win_valid) begin
        checks++;
        if (k >= em.size() || c_max !== em[k]) begin
          errors++;
          $display("FAIL win_max_k2_%0d got %0d want %0d", k, c_max, k < em.size() ? em[k] : 8'd0);
        end
        k++;
      end
      seen_done = c_done;
      @(negedge clk);
    end
    c_valid = 1'b0;
    checks++;
    if (k != 4 || !seen_done) begin
      errors++;
      $display("FAIL win_max_count got %0d windows done=%b want 4 done=1", k, seen_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_random();
`ifdef WIN_MAX_EN
    test_win_max();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
